tank_sprite_scheduler: RTL and testbench
========================================

// Module: tank_sprite_scheduler
// PURPOSE
//  Shares one tank sprite ROM/palette pair between two on-screen tanks.
//  - Per pixel: hit-tests (DrawX,DrawY) against both tank boxes, picks one by priority and issues the ROM address.
//  - Returns the palette index two vga_clk cycles later.
//  - Game logic updates tank positions over a valid/ready handshake; updates commit only at frame start (no tearing).
//  - Sits between game logic and the sprite ROM + palette, ahead of the VGA colour register stage.
// PARAMETERS
//  SPR_W      36  sprite width, pixels
//  SPR_H      36  sprite height, pixels
//  ADDR_W     11  ROM address width; SPR_W*SPR_H <= 2**ADDR_W
//  TRANSP_IDX 0   palette index treated as transparent
// PORTS
//  vga_clk    in   1       pixel clock; all state on posedge
//  reset      in   1       asynchronous, active-high
//  DrawX      in   10      current pixel column
//  DrawY      in   10      current pixel row
//  blank      in   1       1 = active display region
//  pos_valid  in   1       position update request
//  pos_ready  out  1       update accepted when pos_valid & pos_ready
//  pos_sel    in   1       tank selected by the update (0/1)
//  pos_x      in   10      new top-left X for the selected tank
//  pos_y      in   10      new top-left Y for the selected tank
//  rom_addr   out  ADDR_W  registered; ROM samples it on negedge vga_clk
//  rom_q      in   4       ROM data, valid at the following posedge
//  pix_idx    out  4       palette index of the winning sprite pixel
//  pix_hit    out  1       pix_idx is an opaque sprite pixel
//  pix_sel    out  1       tank that produced pix_idx
//  frame_tick out  1       one-cycle pulse after position commit
// BEHAVIOUR
//  Reset state:
//  - All outputs 0, except pos_ready = 1.
//  - Active and shadow positions = 10'h3FF (off-screen; X >= 640 never hits).
//  - pending[1:0] = 0.
//  Handshake and shadow registers:
//  - pos_ready = ~pending[pos_sel] & ~commit.
//  - On accept: shadow[pos_sel] <= {pos_x,pos_y}; pending[pos_sel] <= 1.
//  Commit:
//  - commit = (DrawX,DrawY)==(0,0) while the previous-cycle registered coordinates were not (0,0).
//  - On commit: active <= shadow for each tank with pending set; pending <= 0; frame_tick = 1 next cycle.
//  - pos_ready is forced low in the commit cycle, so commit and accept never coincide.
//  Stage 0 (cycle k, inputs DrawX/DrawY):
//  - hitN = blank & DrawX >= xN & DrawX < xN+SPR_W & DrawY >= yN & DrawY < yN+SPR_H.
//  - Compare in 11 bits so no wrap: sprites partially off right/bottom clip cleanly.
//  - Tank 0 wins if both hit.
//  - rom_addr <= (DrawY-yW)*SPR_W + (DrawX-xW); rom_addr <= 0 when no hit.
//  - hit_d / sel_d registered alongside rom_addr.
//  Stage 1 (cycle k+2):
//  - pix_idx <= rom_q; pix_sel <= sel_d.
//  - pix_hit <= hit_d & (rom_q != TRANSP_IDX).
//  - Latency DrawX -> pix_* = 2 cycles, fixed, including through blanking.
//  Transparency:
//  - A transparent winner pixel yields pix_hit = 0; there is no fallback to the losing tank (single ROM port).
//  Positions:
//  - Positions are 10-bit unsigned; any position with X >= 640 or Y >= 480 is never drawn.
//  Mid-operation reset:
//  - Pipeline, pending and shadow clear immediately; outputs return to reset state asynchronously.
// CONFIGURATION
//  TANK_COLLIDE_EN defined:
//  - Adds output collide (1 bit).
//  - Sticky flag sets whenever hit0 & hit1 in stage 0 (bounding-box overlap on a visible pixel).
//  - At commit the flag is copied to collide (held for the whole next frame) and cleared.
//  - Reset value 0.
//  TANK_COLLIDE_EN undefined:
//  - No collide port, no overlap logic.
//  - Behaviour otherwise identical.
// TESTING
//  - Reset released, tanks at 3FF, full frame scanned -> pix_hit 0 throughout, rom_addr 0, pos_ready 1.
//  - Update tank0 to (100,50) mid-frame -> pos_ready drops for sel 0; no pixel hits until next (0,0).
//    Next frame: DrawX=100,DrawY=50 -> rom_addr 0; DrawX=135,DrawY=85 -> rom_addr 1295; pix_hit 2 cycles later.
//  - Tank0 (100,50), tank1 (110,60); pixel (120,70), rom_q=5 -> rom_addr 20*36+20=740, pix_sel 0, pix_idx 5, pix_hit 1.
//    Same with rom_q=0 -> pix_hit 0.
//  - Tank1 at (620,470); pixel (639,479) -> rom_addr 9*36+19=343; pixel (0,0) -> no hit (no wrap).
//  - Assert pos_valid on the commit cycle -> pos_ready 0; update accepted next cycle; frame_tick pulse seen once.
//  - TANK_COLLIDE_EN: overlapping boxes -> collide 1 after next commit, 0 after following frame without overlap.
//    Reset mid-frame -> collide 0.

Source files
------------

// File: rtl/tank_sprite_scheduler.sv
// Tank sprite scheduler: shares one sprite ROM/palette between two tanks.
// Stage 0 hit-tests the current pixel against both tank boxes and registers the
// ROM address; stage 1 registers the palette index returned by the ROM.
// Position updates arrive over valid/ready and commit only at frame start.
// Optional feature: define TANK_COLLIDE_EN to add the per-frame collide output.
module tank_sprite_scheduler #(
    parameter int unsigned SPR_W      = 36,
    parameter int unsigned SPR_H      = 36,
    parameter int unsigned ADDR_W     = 11,
    parameter logic [3:0]  TRANSP_IDX = 4'd0
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic              pos_sel,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pix_idx,
    output logic              pix_hit,
    output logic              pix_sel,
    output logic              frame_tick
`ifdef TANK_COLLIDE_EN
    ,
    output logic              collide
`endif
);

    logic [1:0][9:0]   act_x, act_y, shd_x, shd_y;
    logic [1:0]        pending;
    logic [9:0]        prev_x, prev_y;
    logic              commit, accept;
    logic              hit0, hit1, any_hit, win_sel;
    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] addr_nxt;
    logic              hit_d, sel_d;

    // 11-bit compare so a box near the right/bottom edge clips instead of wrapping
    function automatic logic in_box(input logic [9:0] d, input logic [9:0] p,
                                    input int unsigned sz);
        logic [10:0] d11, p11;
        d11 = {1'b0, d};
        p11 = {1'b0, p};
        return (d11 >= p11) && (d11 < p11 + 11'(sz));
    endfunction

    // Frame start is the first cycle at (0,0); commit blocks accept that cycle
    assign commit    = (DrawX == 10'd0) && (DrawY == 10'd0) &&
                       ((prev_x != 10'd0) || (prev_y != 10'd0));
    assign pos_ready = ~pending[pos_sel] & ~commit;
    assign accept    = pos_valid & pos_ready;

    // Stage 0 hit test, tank 0 priority and sprite-relative address
    always_comb begin
        hit0     = blank & in_box(DrawX, act_x[0], SPR_W) & in_box(DrawY, act_y[0], SPR_H);
        hit1     = blank & in_box(DrawX, act_x[1], SPR_W) & in_box(DrawY, act_y[1], SPR_H);
        any_hit  = hit0 | hit1;
        win_sel  = ~hit0 & hit1;
        dx       = DrawX - act_x[win_sel];
        dy       = DrawY - act_y[win_sel];
        addr_nxt = '0;
        if (any_hit) begin
            addr_nxt = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
        end
    end

    // Shadow/active position registers, pending flags and frame-start tracking
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            act_x      <= {2{10'h3FF}};
            act_y      <= {2{10'h3FF}};
            shd_x      <= {2{10'h3FF}};
            shd_y      <= {2{10'h3FF}};
            pending    <= 2'b00;
            prev_x     <= 10'h3FF;
            prev_y     <= 10'h3FF;
            frame_tick <= 1'b0;
        end else begin
            prev_x     <= DrawX;
            prev_y     <= DrawY;
            frame_tick <= commit;
            if (commit) begin
                for (int i = 0; i < 2; i++) begin
                    if (pending[i]) begin
                        act_x[i] <= shd_x[i];
                        act_y[i] <= shd_y[i];
                    end
                end
                pending <= 2'b00;
            end else if (accept) begin
                shd_x[pos_sel]   <= pos_x;
                shd_y[pos_sel]   <= pos_y;
                pending[pos_sel] <= 1'b1;
            end
        end
    end

    // Two-stage pixel pipeline: address out, then ROM data back
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            hit_d    <= 1'b0;
            sel_d    <= 1'b0;
            pix_idx  <= 4'd0;
            pix_hit  <= 1'b0;
            pix_sel  <= 1'b0;
        end else begin
            rom_addr <= addr_nxt;
            hit_d    <= any_hit;
            sel_d    <= win_sel;
            pix_idx  <= rom_q;
            pix_sel  <= sel_d;
            pix_hit  <= hit_d & (rom_q != TRANSP_IDX);
        end
    end

`ifdef TANK_COLLIDE_EN
    logic overlap;

    // Sticky overlap flag, published to collide for the whole following frame
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            overlap <= 1'b0;
            collide <= 1'b0;
        end else if (commit) begin
            collide <= overlap;
            overlap <= hit0 & hit1;
        end else if (hit0 & hit1) begin
            overlap <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Self-checking bench for tank_sprite_scheduler: a scoreboard of expected
// pipeline results is filled as pixels are driven and drained as outputs appear.
module tb_tank_sprite_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, pos_valid, pos_sel, pos_ready;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q, pix_idx;
    logic        pix_hit, pix_sel, frame_tick;
`ifdef TANK_COLLIDE_EN
    logic        collide;
`endif

    tank_sprite_scheduler dut (
`ifdef TANK_COLLIDE_EN
        .collide   (collide),
`endif
        .vga_clk   (vga_clk),
        .reset     (reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .pos_sel   (pos_sel),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pix_idx   (pix_idx),
        .pix_hit   (pix_hit),
        .pix_sel   (pix_sel),
        .frame_tick(frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int   addr;
        bit   sel;
        int   idx;
        bit   phit;
        bit   ft;
        bit   col;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ticks = 0;
    bit   zero_mode = 1'b0;

    int   m_ax[2], m_ay[2], m_sx[2], m_sy[2];
    bit   m_pend[2];
    int   m_px, m_py;
    bit   m_ovl, m_col;

    // ROM content model; zero_mode makes address 740 transparent
    function automatic int rom_fn(input int a, input bit z);
        if (z && a == 740) return 0;
        return (a % 16) ^ 1;
    endfunction

    // ROM samples the address on negedge, data valid by next posedge
    always @(negedge vga_clk) rom_q = 4'(rom_fn(int'(rom_addr), zero_mode));

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit in_box(input int d, input int p, input int sz);
        return d >= p && d < p + sz;
    endfunction

    task automatic model_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            m_ax[i] = 1023; m_ay[i] = 1023; m_sx[i] = 1023; m_sy[i] = 1023;
            m_pend[i] = 1'b0;
        end
        m_px = 1023; m_py = 1023; m_ovl = 1'b0; m_col = 1'b0;
        sb.delete();
        e.addr = 0; e.sel = 1'b0; e.idx = rom_fn(0, zero_mode); e.phit = 1'b0;
        e.ft = 1'b0; e.col = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rom_addr", int'(rom_addr), 0);
        check_eq("rst_pix_idx", int'(pix_idx), 0);
        check_eq("rst_pix_hit", int'(pix_hit), 0);
        check_eq("rst_pix_sel", int'(pix_sel), 0);
        check_eq("rst_frame_tick", int'(frame_tick), 0);
        check_eq("rst_pos_ready", int'(pos_ready), 1);
`ifdef TANK_COLLIDE_EN
        check_eq("rst_collide", int'(collide), 0);
`endif
    endtask

    // One pixel: drive, predict, clock, then compare stage-0 and stage-1 outputs
    task automatic cyc(input int x, input int y, input bit b = 1'b1, input bit v = 1'b0,
                       input bit sel = 1'b0, input int px = 0, input int py = 0);
        exp_t e, e0;
        bit   h0, h1, ws, hit, cm, rdy;
        DrawX = 10'(x); DrawY = 10'(y); blank = b;
        pos_valid = v; pos_sel = sel; pos_x = 10'(px); pos_y = 10'(py);
        h0  = b && in_box(x, m_ax[0], 36) && in_box(y, m_ay[0], 36);
        h1  = b && in_box(x, m_ax[1], 36) && in_box(y, m_ay[1], 36);
        ws  = !h0 && h1;
        hit = h0 || h1;
        cm  = x == 0 && y == 0 && (m_px != 0 || m_py != 0);
        rdy = !m_pend[sel] && !cm;
        #1;
        check_eq("pos_ready", int'(pos_ready), int'(rdy));
        e.addr = hit ? (((y - m_ay[ws]) * 36 + (x - m_ax[ws])) % 2048) : 0;
        e.sel  = ws;
        e.idx  = rom_fn(e.addr, zero_mode);
        e.phit = hit && e.idx != 0;
        e.ft   = cm;
        if (cm) begin
            m_col = m_ovl;
            m_ovl = h0 && h1;
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i]) begin
                    m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i];
                end
                m_pend[i] = 1'b0;
            end
        end else begin
            if (h0 && h1) m_ovl = 1'b1;
            if (v && rdy) begin
                m_sx[sel] = px; m_sy[sel] = py; m_pend[sel] = 1'b1;
            end
        end
        e.col = m_col;
        m_px = x; m_py = y;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        check_eq("rom_addr", int'(rom_addr), sb[$].addr);
        check_eq("frame_tick", int'(frame_tick), int'(sb[$].ft));
`ifdef TANK_COLLIDE_EN
        check_eq("collide", int'(collide), int'(sb[$].col));
`endif
        e0 = sb.pop_front();
        check_eq("pix_idx", int'(pix_idx), e0.idx);
        check_eq("pix_hit", int'(pix_hit), int'(e0.phit));
        check_eq("pix_sel", int'(pix_sel), int'(e0.sel));
        if (frame_tick) n_ticks++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
        pos_valid = 1'b0; pos_sel = 1'b0; pos_x = '0; pos_y = '0;
        repeat (2) @(negedge vga_clk);
        check_reset_outputs();
        reset = 1'b0;
        model_reset();

        // Empty scene: sparse full-frame scan, nothing may hit
        cyc(1, 1);
        for (int y = 0; y < 480; y += 16)
            for (int x = 0; x < 640; x += 16)
                cyc(x, y);

        // Tank 0 update mid-frame: held in shadow until frame start
        cyc(200, 200, 1, 1, 0, 100, 50);
        cyc(201, 200, 1, 1, 0, 300, 300);
        cyc(100, 50);
        cyc(120, 70);
        cyc(0, 0);
        cyc(100, 50);
        check_eq("addr_100_50", int'(rom_addr), 0);
        cyc(135, 85);
        check_eq("addr_135_85", int'(rom_addr), 1295);
        cyc(136, 85);
        check_eq("hit_135_85", int'(pix_hit), 1);
        cyc(100, 50, 0);

        // Overlap priority and transparency
        cyc(300, 300, 1, 1, 1, 110, 60);
        cyc(0, 0);
        cyc(120, 70);
        check_eq("addr_120_70", int'(rom_addr), 740);
        cyc(700, 10);
        check_eq("idx_120_70", int'(pix_idx), 5);
        check_eq("hit_120_70", int'(pix_hit), 1);
        check_eq("sel_120_70", int'(pix_sel), 0);
        zero_mode = 1'b1;
        cyc(120, 70);
        cyc(700, 10);
        check_eq("transp_hit", int'(pix_hit), 0);
        zero_mode = 1'b0;
        cyc(700, 10);

        // Bottom-right clipping, no wrap to (0,0)
        cyc(300, 300, 1, 1, 1, 620, 470);
        cyc(0, 0);
        cyc(639, 479);
        check_eq("addr_639_479", int'(rom_addr), 343);
        cyc(0, 0);
        cyc(5, 5);
        check_eq("nowrap_hit", int'(pix_hit), 0);

        // Request on the commit cycle is refused, then accepted
        cyc(10, 10);
        n_ticks = 0;
        cyc(0, 0, 1, 1, 0, 200, 100);
        cyc(1, 0, 1, 1, 0, 200, 100);
        cyc(2, 0, 1, 1, 0, 300, 300);
        check_eq("tick_count", n_ticks, 1);
        cyc(0, 0);
        cyc(200, 100);
        check_eq("addr_200_100", int'(rom_addr), 0);

        // Overlapping boxes for one frame, then a frame without overlap
        cyc(50, 50, 1, 1, 1, 210, 110);
        cyc(0, 0);
        cyc(215, 115);
        cyc(220, 120);
        cyc(0, 0);
        cyc(5, 5);
        cyc(0, 0);
        cyc(215, 115);

        // Asynchronous reset mid-frame
        #2;
        DrawX = 10'd5; DrawY = 10'd5; pos_valid = 1'b0;
        reset = 1'b1;
        #2;
        check_reset_outputs();
        @(negedge vga_clk);
        reset = 1'b0;
        model_reset();
        cyc(215, 115);
        cyc(120, 70);
        cyc(100, 50);
        cyc(700, 10);
        check_eq("post_rst_hit", int'(pix_hit), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
